// File: rtl/ibn_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package ibn_pkg;

  localparam int unsigned IMEM_AW_DEFAULT = 8;
  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned RELEASE_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN
  } ld_state_e;

endpackage

// File: rtl/ibn_sync2.sv
// Multi-flop synchronizer for a single quasi-static or toggle signal.
module ibn_sync2
  import ibn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/ibn_prog_loader.sv
// Loads instruction words from the logic analyzer into IMEM while holding
// the core in reset, then releases the core after a short reset tail.
module ibn_prog_loader
  import ibn_pkg::*;
#(
  parameter int unsigned IMEM_AW = IMEM_AW_DEFAULT
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               ld_mode_i,
  input  logic               ld_strobe_i,
  input  logic [31:0]        ld_data_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  output logic               core_rst_o,
  output logic               ld_ack_o,
  output logic [IMEM_AW:0]   ld_count_o,
  output logic               ld_err_o
);

  localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  ld_state_e   state;
  logic        mode_s;
  logic        strobe_s;
  logic        strobe_d;
  logic        strobe_evt;
  logic [RW-1:0] rel_cnt;

  ibn_sync2 u_mode_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (ld_mode_i),
    .q   (mode_s)
  );

  ibn_sync2 u_strobe_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (ld_strobe_i),
    .q   (strobe_s)
  );

  assign strobe_evt = strobe_s ^ strobe_d;

  // strobe_d tracks in every state so a toggle made outside LOAD is
  // consumed there and never replayed when LOAD is entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      core_rst_o   <= 1'b1;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      ld_ack_o     <= 1'b0;
      ld_count_o   <= '0;
      ld_err_o     <= 1'b0;
      strobe_d     <= 1'b0;
      rel_cnt      <= '0;
    end else begin
      strobe_d  <= strobe_s;
      imem_we_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          core_rst_o <= 1'b1;
          if (mode_s) begin
            state       <= ST_LOAD;
            ld_count_o  <= '0;
            ld_err_o    <= 1'b0;
            imem_addr_o <= '0;
          end else begin
            state   <= ST_RELEASE;
            rel_cnt <= '0;
          end
        end
        ST_LOAD: begin
          core_rst_o <= 1'b1;
          // A word arriving together with the mode drop is still handled here.
          if (strobe_evt) begin
            ld_ack_o <= ~ld_ack_o;
            if (ld_count_o[IMEM_AW]) begin
              ld_err_o <= 1'b1;
            end else begin
              imem_we_o    <= 1'b1;
              imem_addr_o  <= ld_count_o[IMEM_AW-1:0];
              imem_wdata_o <= ld_data_i;
              ld_count_o   <= ld_count_o + (IMEM_AW+1)'(1);
            end
          end
          if (!mode_s) begin
            state   <= ST_RELEASE;
            rel_cnt <= '0;
          end
        end
        ST_RELEASE: begin
          core_rst_o <= 1'b1;
          if (rel_cnt == REL_LAST) begin
            state      <= ST_RUN;
            core_rst_o <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + RW'(1);
          end
        end
        ST_RUN: begin
          if (mode_s) begin
            state       <= ST_LOAD;
            core_rst_o  <= 1'b1;
            ld_count_o  <= '0;
            ld_err_o    <= 1'b0;
            imem_addr_o <= '0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          core_rst_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
